rx_fifo_funcmod: RTL and testbench
==================================

// Module: rx_fifo_funcmod
// PURPOSE
//  Downstream stage of the UART receive function module. Holds the rx side permanently called,
//  captures each byte delivered on its one-cycle done pulse and queues it in a small FIFO.
//  Returns bytes to the consumer through the team's iCall/oDone call-done handshake.
//  Decouples bursty 115200-baud reception from a slower or busier consumer.
// PARAMETERS
//  AW     4    FIFO address width; DEPTH = 2**AW entries (default 16)
//  DW     8    data width; matches rx byte width
// PORTS
//  CLOCK    in   1      system clock; all logic on posedge
//  RESET    in   1      asynchronous, active-low reset
//  oRxCall  out  1      call to rx module; drives its iCall
//  iRxDone  in   1      rx byte-done pulse, 1 cycle wide
//  iRxData  in   DW     rx byte, valid while iRxDone=1
//  iCall    in   1      consumer read request, level
//  oDone    out  1      1-cycle pulse, oData valid for that cycle and held after it
//  oData    out  DW     byte popped from FIFO
//  oCount   out  AW+1   entries currently stored, 0..DEPTH
//  oEmpty   out  1      oCount==0
//  oFull    out  1      oCount==DEPTH
// BEHAVIOUR
//  Reset values: oRxCall=0, oDone=0, oData=0, oCount=0, oEmpty=1, oFull=0; wptr=rptr=0; read step=0.
//  oRxCall: registered; 1 from the first clock after reset release, then constant 1.
//   Never deasserted while full, because a mid-frame drop would freeze rx bit timing.
//  Write: on iRxDone=1 with oFull=0, mem[wptr]<=iRxData, wptr+1 (wraps mod DEPTH), count+1.
//   iRxDone=1 with oFull=1: byte dropped, no state change except the overflow flag (see CONFIGURATION).
//  Read step machine (i):
//   0: if iCall && !oEmpty: oData<=mem[rptr], rptr+1 (wrap), count-1, i<=1; else stay in 0.
//   1: oDone<=1, i<=2.
//   2: oDone<=0, i<=0.
//  Latency: iCall=1 sampled at edge N with data present -> oDone=1 during cycle N+2.
//   With iCall held high, pops occur back-to-back every 3 cycles.
//  iCall dropped in step 1 or 2: the in-flight pop still completes. No pop is ever cancelled.
//  Simultaneous write and pop in one cycle: count unchanged, both pointers advance.
//   Full/empty decisions use the registered count from before that edge.
//   Case full + pop + iRxDone: write dropped, count becomes DEPTH-1.
//  Case empty + write + iCall: no pop this edge; pop happens on the next edge (count=1).
//  oEmpty and oFull are registered; they update on the same edge as oCount.
//  Pointers are AW bits wide. Count is AW+1 bits, so DEPTH is distinguishable from 0.
//  Reset mid-operation: pointers, count and step return to reset values; FIFO contents are lost.
//   Memory array is not cleared.
// CONFIGURATION
//  RX_FIFO_OVERFLOW_EN defined: adds output oOverflow (1 bit, reset 0).
//   Set sticky on any dropped write.
//   Cleared on the edge where step 0 starts a pop and no drop occurs that same edge.
//   If both happen on the same edge, the set wins.
//  Not defined: no oOverflow port; dropped writes are silent.
//  FIFO datapath is identical in both builds.
// STRUCTURE
//  Shared header rx_defs.vh:
//   RX_DW=8
//   default AW
//   read step codes RD_IDLE=0, RD_PULSE=1, RD_CLR=2
//  Sub-module rx_fifo_mem: DEPTH x DW register array.
//   Synchronous write port (we, waddr, wdata).
//   Combinational read at raddr.
//   No reset on storage.
//  Top level holds the pointers, count, flags, oRxCall and the read step machine.
// TESTING
//  T1 reset, then rx delivers 0x55: oRxCall=1 by the 2nd cycle; oCount=1, oEmpty=0.
//   iCall=1 -> oDone pulse 2 cycles later, oData=0x55, oCount=0.
//  T2 write 16 bytes 0x00..0x0F with no reads: oFull=1, oCount=16.
//   17th byte 0xAA is dropped; with RX_FIFO_OVERFLOW_EN, oOverflow=1.
//   Drain returns 0x00..0x0F in order and never 0xAA.
//  T3 20 write/read cycles interleaved so pointers wrap past 15->0: FIFO order is preserved,
//   oCount never exceeds 16 or underflows.
//  T4 full FIFO, iRxDone and pop on the same edge: oCount=15, new byte dropped.
//   Empty FIFO, iRxDone and iCall together: pop one cycle later, oData equals the new byte.
//  T5 iCall held high with 3 bytes queued: three oDone pulses spaced 3 cycles apart,
//   then none while empty.
//   iCall dropped during step 1: that pulse still occurs.
//  T6 RESET asserted mid-drain with oCount=5: all outputs return to reset values asynchronously.
//   After release, a new byte 0x3C is read back correctly.

Source files
------------

// File: rtl/rx_fifo_funcmod_pkg.sv
// Shared constants and read step encoding for the UART receive FIFO stage.
package rx_fifo_funcmod_pkg;

  localparam int RX_DW = 8;
  localparam int RX_AW = 4;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PULSE = 2'd1,
    RD_CLR   = 2'd2
  } rd_step_e;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x DW register array: synchronous write, combinational read, storage not reset.
module rx_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo_funcmod.sv
// UART rx downstream FIFO: keeps rx called, queues done-pulsed bytes, returns them via iCall/oDone.
// Optional build macro RX_FIFO_OVERFLOW_EN adds a sticky oOverflow output.
module rx_fifo_funcmod
  import rx_fifo_funcmod_pkg::*;
#(
  parameter int AW = RX_AW,
  parameter int DW = RX_DW
) (
  input  logic          CLOCK,
  input  logic          RESET,
  output logic          oRxCall,
  input  logic          iRxDone,
  input  logic [DW-1:0] iRxData,
  input  logic          iCall,
  output logic          oDone,
  output logic [DW-1:0] oData,
  output logic [AW:0]   oCount,
  output logic          oEmpty,
  output logic          oFull,
`ifdef RX_FIFO_OVERFLOW_EN
  output logic          oOverflow,
`endif
  output logic [1:0]    oDbgStep
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Handshake: iCall is a level request; oDone is a one-cycle pulse with oData
  // valid in that cycle and held afterwards. A started pop always completes.
  rd_step_e        step_q, step_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            done_q, done_d, rx_call_q;
  logic [DW-1:0]   data_q, data_d, mem_rdata;
  logic            wr, pop, drop;

  rx_fifo_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk   (CLOCK),
    .we    (wr),
    .waddr (wptr_q),
    .wdata (iRxData),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  // Full/empty decisions use the registered flags from before this edge.
  assign wr   = iRxDone && !full_q;
  assign drop = iRxDone && full_q;
  assign pop  = (step_q == RD_IDLE) && iCall && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    data_d  = data_q;
    done_d  = done_q;
    step_d  = step_q;
    if (wr)  wptr_d = wptr_q + PTR_ONE;
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
      data_d = mem_rdata;
    end
    unique case ({wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_MAX);
    unique case (step_q)
      RD_IDLE:  if (pop) step_d = RD_PULSE;
      RD_PULSE: begin
        done_d = 1'b1;
        step_d = RD_CLR;
      end
      RD_CLR: begin
        done_d = 1'b0;
        step_d = RD_IDLE;
      end
      default: begin
        done_d = 1'b0;
        step_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      step_q    <= RD_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      rx_call_q <= 1'b0;
    end else begin
      step_q    <= step_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      done_q    <= done_d;
      data_q    <= data_d;
      // Never dropped once raised: deasserting mid-frame would break rx bit timing.
      rx_call_q <= 1'b1;
    end
  end

`ifdef RX_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (pop)  ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign oOverflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign oRxCall  = rx_call_q;
  assign oDone    = done_q;
  assign oData    = data_q;
  assign oCount   = count_q;
  assign oEmpty   = empty_q;
  assign oFull    = full_q;
  assign oDbgStep = step_q;

endmodule

// File: tb/tb_rx_fifo_funcmod.sv
// Self-checking bench for rx_fifo_funcmod: scoreboard of accepted bytes checked against oDone pops.
module tb_rx_fifo_funcmod;

  logic       clk;
  logic       rst_n;
  logic       rx_call;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       call;
  logic       done;
  logic [7:0] data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic [1:0] dbg_step;
`ifdef RX_FIFO_OVERFLOW_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  rx_fifo_funcmod dut (
    .CLOCK    (clk),
    .RESET    (rst_n),
    .oRxCall  (rx_call),
    .iRxDone  (rx_done),
    .iRxData  (rx_data),
    .iCall    (call),
    .oDone    (done),
    .oData    (data),
    .oCount   (count),
    .oEmpty   (empty),
    .oFull    (full),
`ifdef RX_FIFO_OVERFLOW_EN
    .oOverflow(ovf),
`endif
    .oDbgStep (dbg_step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every oDone pops the oldest accepted byte
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("spurious_done", {24'd0, data}, 32'hFFFF_FFFF);
      else                   check("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
  end

  // drivers: all called and returning at a negedge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit keep);
    rx_done = 1'b1;
    rx_data = b;
    if (keep) exp_q.push_back(b);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic read_one();
    call = 1'b1;
    @(negedge clk);
    call = 1'b0;
    @(negedge clk);
    check("done_latency", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_width", {31'd0, done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxcall"}, {31'd0, rx_call}, 32'd0);
    check({tag, "_done"},   {31'd0, done},    32'd0);
    check({tag, "_data"},   {24'd0, data},    32'd0);
    check({tag, "_count"},  {27'd0, count},   32'd0);
    check({tag, "_empty"},  {31'd0, empty},   32'd1);
    check({tag, "_full"},   {31'd0, full},    32'd0);
`ifdef RX_FIFO_OVERFLOW_EN
    check({tag, "_ovf"},    {31'd0, ovf},     32'd0);
`endif
  endtask

  initial begin
    int first_k;
    int last_k;
    int pulses;
    bit seen;
    logic [7:0] b;

    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    call    = 1'b0;
    cyc(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // T1
    cyc(1);
    check("rxcall_up", {31'd0, rx_call}, 32'd1);
    push_byte(8'h55, 1'b1);
    check("t1_count", {27'd0, count}, 32'd1);
    check("t1_empty", {31'd0, empty}, 32'd0);
    read_one();
    check("t1_count_after", {27'd0, count}, 32'd0);
    check("t1_data_held", {24'd0, data}, 32'h55);

    // T2
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_count", {27'd0, count}, 32'd16);
    push_byte(8'hAA, 1'b0);
    check("t2_count_drop", {27'd0, count}, 32'd16);
`ifdef RX_FIFO_OVERFLOW_EN
    check("t2_ovf_set", {31'd0, ovf}, 32'd1);
`endif
    for (int i = 0; i < 16; i++) read_one();
    check("t2_drained", {27'd0, count}, 32'd0);
    check("t2_empty", {31'd0, empty}, 32'd1);
`ifdef RX_FIFO_OVERFLOW_EN
    check("t2_ovf_clr", {31'd0, ovf}, 32'd0);
`endif

    // T3: pointers wrap while 3 bytes stay queued
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 20; i++) begin
      push_byte(8'($urandom_range(0, 255)), 1'b1);
      read_one();
      check("t3_count", {27'd0, count}, 32'd3);
    end
    for (int i = 0; i < 3; i++) read_one();
    check("t3_count_end", {27'd0, count}, 32'd0);

    // T4: full + pop + write on one edge
    for (int i = 0; i < 16; i++) push_byte(8'(i * 3 + 1), 1'b1);
    check("t4_full", {31'd0, full}, 32'd1);
    rx_done = 1'b1;
    rx_data = 8'hEE;
    call    = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    call    = 1'b0;
    check("t4_count15", {27'd0, count}, 32'd15);
    check("t4_not_full", {31'd0, full}, 32'd0);
`ifdef RX_FIFO_OVERFLOW_EN
    check("t4_ovf_set_wins", {31'd0, ovf}, 32'd1);
`endif
    cyc(2);
    for (int i = 0; i < 15; i++) read_one();
    check("t4_drained", {27'd0, count}, 32'd0);

    // T4: empty + write + call: pop one edge later
    rx_done = 1'b1;
    rx_data = 8'h99;
    call    = 1'b1;
    exp_q.push_back(8'h99);
    @(negedge clk);
    rx_done = 1'b0;
    check("t4_empty_wr_count", {27'd0, count}, 32'd1);
    check("t4_empty_no_pop", {30'd0, dbg_step}, 32'd0);
    @(negedge clk);
    call = 1'b0;
    check("t4_late_pop_count", {27'd0, count}, 32'd0);
    @(negedge clk);
    check("t4_late_pop_done", {31'd0, done}, 32'd1);
    check("t4_late_pop_data", {24'd0, data}, 32'h99);
    cyc(1);

    // T5: iCall held high with three bytes queued
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1'b1);
    call    = 1'b1;
    pulses  = 0;
    first_k = -1;
    last_k  = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_k < 0) first_k = k;
        else             check("t5_spacing", 32'(k - last_k), 32'd3);
        last_k = k;
        pulses++;
      end
    end
    call = 1'b0;
    check("t5_first_pulse", 32'(first_k), 32'd1);
    check("t5_pulses", 32'(pulses), 32'd3);

    // T5: iCall dropped in step 1 still completes the pop
    push_byte(8'h77, 1'b1);
    call = 1'b1;
    @(negedge clk);
    call = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("t5_no_cancel", {31'd0, seen}, 32'd1);

    // T6: async reset mid-drain
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i), 1'b1);
    read_one();
    check("t6_count5", {27'd0, count}, 32'd5);
    call = 1'b1;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    check("t6_step", {30'd0, dbg_step}, 32'd0);
    exp_q.delete();
    call = 1'b0;
    @(negedge clk);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("t6_rxcall", {31'd0, rx_call}, 32'd1);
    push_byte(8'h3C, 1'b1);
    check("t6_count1", {27'd0, count}, 32'd1);
    read_one();
    check("t6_data", {24'd0, data}, 32'h3C);

    cyc(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
